// File: rtl/apb_slave_regfile.sv
// APB completer: word-addressed 32-bit register file with programmable wait
// states and error reporting. The last register is a read-only counter of
// successfully completed transfers.
//
// Ports:
//   Hclk     clock, all state changes on the rising edge
//   Hreset   asynchronous active-low reset
//   Psel     completer select
//   Penable  access-phase indicator
//   Pwrite   1 = write, 0 = read
//   Paddr    byte address
//   Pwdata   write data
//   Prdata   read data, valid only when Pready=1 on a read (0 otherwise)
//   Pready   transfer completes on the edge where Psel&Penable&Pready
//   Pslverr  error response, valid only when Pready=1 (0 otherwise)
//   reg0_q   current value of register 0
module apb_slave_regfile #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned NREGS       = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic [31:0] reg0_q
);

  localparam int unsigned IW = $clog2(NREGS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);
  localparam logic [IW-1:0] REG0_IDX = '0;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;
  logic          cap_write;
  logic [3:0]    wcnt;
  logic [31:0]   regs [NREGS];

  logic [31:0]   off;
  logic [29:0]   idx;
  logic [IW-1:0] sel;
  logic          err;
  logic          setup;
  logic          commit;

  // Decode works only from the values captured in the setup phase, so bus
  // changes during the access phase cannot disturb the transfer.
  assign off = cap_addr - BASE_ADDR;
  assign idx = off[31:2];
  assign sel = idx[IW-1:0];
  assign err = (off[1:0] != 2'b00)
             | ({2'b00, idx} >= 32'(NREGS))
             | (cap_write & ({2'b00, idx} == 32'(NREGS - 1)));

  // Pready depends on registered state only, never on the bus inputs.
  assign Pready  = (state == ACCESS) && (wcnt == '0);
  assign setup   = (state == IDLE) & Psel & ~Penable;
  assign commit  = Pready & Psel & Penable;
  assign Pslverr = Pready & err;
  assign Prdata  = (Pready & ~err & ~cap_write) ? regs[sel] : '0;
  assign reg0_q  = regs[REG0_IDX];

  always_ff @(posedge Hclk or negedge Hreset) begin
    if (!Hreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (setup) state_nxt = ACCESS;
      ACCESS: begin
        if (!Psel)       state_nxt = IDLE;  // protocol violation: abort
        else if (commit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hreset) begin
    if (!Hreset) begin
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_write <= 1'b0;
      wcnt      <= '0;
    end else if (setup) begin
      cap_addr  <= Paddr;
      cap_wdata <= Pwdata;
      cap_write <= Pwrite;
      wcnt      <= 4'(WAIT_CYCLES);
    end else if (state == ACCESS && wcnt != '0) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  // Writes to the counter slot are flagged as errors, so the data write and
  // the counter increment never target the same register on one edge.
  always_ff @(posedge Hclk or negedge Hreset) begin
    if (!Hreset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (commit && !err) begin
      if (cap_write) regs[sel] <= cap_wdata;
      regs[LAST_IDX] <= regs[LAST_IDX] + 32'd1;
    end
  end

endmodule
